// File: rtl/isu_mesh.sv
// -----------------------------------------------------------------------------
// isu_mesh
//
// Entropy conditioner built from pipelined ISU (invert/swap unit) stages.
// Each raw sample is captured together with a control word taken from a
// free-running (capture-stepped) LFSR. The sample then passes through STAGES
// registered layers of ISU cells. Each layer uses the control word rotated by
// its stage index, and the data word is rotated left by one bit between
// layers. The output side is a valid/ready handshake. A repetition-count
// health test watches the transferred words and latches rct_fail when too
// many identical words arrive in a row. After a failure no new samples are
// captured; words already in flight still drain.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   en         request to capture raw_in this cycle
//   raw_in     raw entropy sample            [WIDTH]
//   seed_load  load seed into the control LFSR
//   seed       LFSR seed (zero is replaced by 1) [WIDTH]
//   rnd_data   mixed output word             [WIDTH]
//   rnd_valid  rnd_data holds an unconsumed word
//   rnd_ready  consumer accepts rnd_data
//   rct_fail   sticky repetition-count failure
// -----------------------------------------------------------------------------
module isu_mesh #(
    parameter int WIDTH     = 8,
    parameter int STAGES    = 4,
    parameter int RCT_LIMIT = 31
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] raw_in,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] rnd_data,
    output logic             rnd_valid,
    input  logic             rnd_ready,
    output logic             rct_fail
);

    localparam int             NCELL   = WIDTH / 2;
    localparam int             CNT_W   = $clog2(RCT_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(RCT_LIMIT);
    localparam logic [WIDTH-1:0] LFSR_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Rotate left by a constant amount.
    function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int amt);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[(i + amt) % WIDTH] = v[i];
        end
        return r;
    endfunction

    // One layer of ISU cells. Cell k works on bit pair (2k, 2k+1);
    // the result is always inverted and the pair is swapped when m^n.
    function automatic logic [WIDTH-1:0] isu_layer(input logic [WIDTH-1:0] b,
                                                   input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] a;
        logic             x;
        logic             y;
        a = '0;
        for (int k = 0; k < NCELL; k++) begin
            x          = c[2*k+1] ? b[2*k+1] : b[2*k];
            y          = c[2*k+1] ? b[2*k]   : b[2*k+1];
            a[2*k]     = c[2*k] ? ~y : ~x;
            a[2*k+1]   = c[2*k] ? ~x : ~y;
        end
        return a;
    endfunction

    // Pipeline taps: index 0 is the input register, index s+1 is stage s.
    logic [WIDTH-1:0] w_data  [0:STAGES];
    logic             w_valid [0:STAGES];
    // Control word travels only as far as the last stage that needs it.
    logic [WIDTH-1:0] w_ctrl  [0:STAGES-1];

    logic w_advance;
    logic w_capture;
    logic w_xfer;

    logic [WIDTH-1:0] r_lfsr;
    logic [WIDTH-1:0] r_in_data;
    logic [WIDTH-1:0] r_in_ctrl;
    logic             r_in_valid;

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             r_seen;
    logic [WIDTH-1:0] r_last;
    logic             r_fail;

    assign w_advance = !rnd_valid || rnd_ready;
    assign w_capture = en && w_advance && !r_fail;
    assign w_xfer    = rnd_valid && rnd_ready;

    // Control LFSR; a load wins over stepping, and a capture in the same
    // cycle already sampled the old value through r_lfsr.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_ONE;
        end else if (seed_load) begin
            r_lfsr <= (seed == '0) ? LFSR_ONE : seed;
        end else if (w_capture) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-2]};
        end
    end

    // Input register: sample + control word + valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_data  <= '0;
            r_in_ctrl  <= '0;
            r_in_valid <= 1'b0;
        end else if (w_advance) begin
            r_in_valid <= w_capture;
            if (w_capture) begin
                r_in_data <= raw_in;
                r_in_ctrl <= r_lfsr;
            end
        end
    end

    assign w_data[0]  = r_in_data;
    assign w_valid[0] = r_in_valid;
    assign w_ctrl[0]  = r_in_ctrl;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            localparam int ROT = gi % WIDTH;

            logic [WIDTH-1:0] w_b;
            logic [WIDTH-1:0] w_c;
            logic [WIDTH-1:0] r_data;
            logic             r_valid;

            // Inter-stage rotate sits in front of every stage but the first.
            if (gi == 0) begin : g_first
                assign w_b = w_data[0];
            end else begin : g_rot
                assign w_b = rotl(w_data[gi], 1);
            end
            assign w_c = rotl(w_ctrl[gi], ROT);

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_data  <= '0;
                    r_valid <= 1'b0;
                end else if (w_advance) begin
                    r_data  <= isu_layer(w_b, w_c);
                    r_valid <= w_valid[gi];
                end
            end

            assign w_data[gi+1]  = r_data;
            assign w_valid[gi+1] = r_valid;

            if (gi < STAGES - 1) begin : g_ctrl
                logic [WIDTH-1:0] r_ctrl;
                always_ff @(posedge clk) begin
                    if (!rst_n) begin
                        r_ctrl <= '0;
                    end else if (w_advance) begin
                        r_ctrl <= w_ctrl[gi];
                    end
                end
                assign w_ctrl[gi+1] = r_ctrl;
            end
        end
    endgenerate

    assign rnd_data  = w_data[STAGES];
    assign rnd_valid = w_valid[STAGES];

    // Repetition count: the very first transfer only primes last_word.
    always_comb begin
        w_cnt_next = '0;
        if (r_seen && (rnd_data == r_last)) begin
            w_cnt_next = (r_cnt == CNT_LIM) ? r_cnt : r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_seen <= 1'b0;
            r_last <= '0;
            r_fail <= 1'b0;
        end else if (w_xfer) begin
            r_seen <= 1'b1;
            r_last <= rnd_data;
            r_cnt  <= w_cnt_next;
            if (w_cnt_next == CNT_LIM) begin
                r_fail <= 1'b1;
            end
        end
    end

    assign rct_fail = r_fail;

endmodule
